sysid_check_master: RTL

- Avalon-MM read master that fetches the two system-ID words from the mysystem system-ID slave: word 0 is the ID, word 1 is the timestamp.
- Compares both words against build-time constants and reports pass/fail.
- Sits next to the boot/reset controller in mysystem; its pass output gates audio-path enable so a mismatched FPGA image cannot start playback.

---
 rtl/mysystem_pkg.sv | 18 +
 rtl/avm_read_timer.sv | 29 ++
 rtl/sysid_check_master.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mysystem_pkg.sv
// Shared mysystem definitions: system-ID word map, default ID values
// and the sysid checker state encoding.
package mysystem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_ID = 2'd1,
        ST_RD_TS = 2'd2,
        ST_DONE  = 2'd3
    } sysid_chk_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_EXPECTED_ID        = 32'h87654321;
    localparam logic [31:0] SYSID_EXPECTED_TIMESTAMP = 32'd1766840597;

endpackage

// File: rtl/avm_read_timer.sv
// Waitrequest stall counter for one Avalon read; expired once the
// count has reached TIMEOUT_CYCLES.
module avm_read_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the system-ID and timestamp
// words and compares them with the build-time constants.
module sysid_check_master
    import mysystem_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_EXPECTED_TIMESTAMP,
    parameter bit          CHECK_TIMESTAMP    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_timestamp
);

    sysid_chk_state_t state, state_n;

    logic auto_pending;
    logic launch;
    logic rd_active;
    logic rd_ok;
    logic rd_abort;
    logic expired;
    logic id_n, ts_n, to_n, pass_n;

    always_comb begin
        launch    = (state == ST_IDLE) && (start || auto_pending);
        rd_active = (state == ST_RD_ID) || (state == ST_RD_TS);
        rd_ok     = rd_active && !avm_waitrequest;
        rd_abort  = rd_active && avm_waitrequest && expired;
        id_n = id_mismatch |
               ((state == ST_RD_ID) && rd_ok && (avm_readdata != EXPECTED_ID));
        ts_n = ts_mismatch |
               ((state == ST_RD_TS) && rd_ok &&
                (avm_readdata != EXPECTED_TIMESTAMP));
        to_n   = timeout | rd_abort;
        pass_n = !to_n && !id_n && !(ts_n && CHECK_TIMESTAMP);
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (launch) state_n = ST_RD_ID;
            ST_RD_ID: begin
                if (rd_ok)         state_n = ST_RD_TS;
                else if (rd_abort) state_n = ST_DONE;
            end
            ST_RD_TS: if (rd_ok || rd_abort) state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    avm_read_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (launch || rd_ok),
        .enable (rd_active && avm_waitrequest && !expired),
        .expired(expired)
    );

    // Bus strobes and status are registered from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            auto_pending       <= AUTO_START;
            avm_read           <= 1'b0;
            avm_address        <= SYSID_ADDR_ID;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            id_mismatch        <= 1'b0;
            ts_mismatch        <= 1'b0;
            timeout            <= 1'b0;
            captured_id        <= '0;
            captured_timestamp <= '0;
        end else begin
            state    <= state_n;
            avm_read <= (state_n == ST_RD_ID) || (state_n == ST_RD_TS);
            avm_address <= (state_n == ST_RD_TS) ? SYSID_ADDR_TS
                                                 : SYSID_ADDR_ID;
            busy <= (state_n != ST_IDLE);
            done <= (state_n == ST_DONE);
            if (launch) begin
                auto_pending       <= 1'b0;
                pass               <= 1'b0;
                id_mismatch        <= 1'b0;
                ts_mismatch        <= 1'b0;
                timeout            <= 1'b0;
                captured_id        <= '0;
                captured_timestamp <= '0;
            end else begin
                id_mismatch <= id_n;
                ts_mismatch <= ts_n;
                timeout     <= to_n;
                if ((state == ST_RD_ID) && rd_ok)
                    captured_id <= avm_readdata;
                if ((state == ST_RD_TS) && rd_ok)
                    captured_timestamp <= avm_readdata;
                if (state_n == ST_DONE)
                    pass <= pass_n;
            end
        end
    end

endmodule
